// File: rtl/obstacle_spawn_scheduler.sv
// Obstacle spawn scheduler: paces spawns with a tick-driven gap counter, allocates the lowest free
// slot, offers each spawn over valid/ready and owns the difficulty level and per-move dx.
module obstacle_spawn_scheduler #(
  parameter int unsigned NUM_SLOTS   = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned FIRST_GAP   = 60,
  parameter int unsigned MIN_GAP     = 40,
  parameter int unsigned LEVEL_TICKS = 1000,
  parameter int unsigned MAX_LEVEL   = 7,
  parameter int unsigned BASE_DX     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 tick,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic                 spawn_ready,
  output logic                 spawn_valid,
  output logic [1:0]           spawn_slot,
  output logic [1:0]           spawn_type,
  output logic [2:0]           speed_level,
  output logic [4:0]           dx
);

  localparam int unsigned LevelCntW = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
  localparam logic [LevelCntW-1:0] LevelLast = LevelCntW'(LEVEL_TICKS - 1);
  localparam logic [7:0]  FirstGap = 8'(FIRST_GAP);
  localparam logic [7:0]  MinGap   = 8'(MIN_GAP);
  localparam logic [2:0]  MaxLevel = 3'(MAX_LEVEL);
  localparam logic [4:0]  BaseDx   = 5'(BASE_DX);
  localparam logic [15:0] LfsrMask = 16'hB400;

  typedef enum logic [1:0] {StGap, StAlloc, StOffer} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [LevelCntW-1:0]   level_cnt_q, level_cnt_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   valid_q, valid_d;
  logic [1:0]             slot_q, slot_d;
  logic [1:0]             type_q, type_d;
  logic [2:0]             speed_level_q, speed_level_d;
  logic [4:0]             dx_q, dx_d;

  logic                   free_found;
  logic [1:0]             free_idx;
  logic [1:0]             raw_type;
  logic [1:0]             sel_type;
  logic [7:0]             gap_reload;

  // Lowest-index free slot wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  // Birds are held back until level 2; they fall back to a small cactus.
  assign raw_type   = lfsr_q[7:6];
  assign sel_type   = (raw_type == 2'd3 && speed_level_q < 3'd2) ? 2'd0 : raw_type;
  assign gap_reload = MinGap + ({2'b00, lfsr_q[5:0]} >> speed_level_q[2:1]);

  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    level_cnt_d   = level_cnt_q;
    lfsr_d        = lfsr_q;
    valid_d       = valid_q;
    slot_d        = slot_q;
    type_d        = type_q;
    speed_level_d = speed_level_q;
    dx_d          = dx_q;

    if (run) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);

      if (tick) begin
        if (level_cnt_q == LevelLast) begin
          level_cnt_d = '0;
          if (speed_level_q < MaxLevel) begin
            speed_level_d = speed_level_q + 3'd1;
          end
        end else begin
          level_cnt_d = level_cnt_q + LevelCntW'(1);
        end
      end
      dx_d = BaseDx + {2'b00, speed_level_d};

      unique case (state_q)
        StGap: begin
          if (tick) begin
            if (gap_cnt_q <= 8'd1) begin
              gap_cnt_d = 8'd0;
              state_d   = StAlloc;
            end else begin
              gap_cnt_d = gap_cnt_q - 8'd1;
            end
          end
        end
        StAlloc: begin
          if (free_found) begin
            slot_d  = free_idx;
            type_d  = sel_type;
            valid_d = 1'b1;
            state_d = StOffer;
          end
        end
        StOffer: begin
          if (spawn_ready) begin
            valid_d   = 1'b0;
            gap_cnt_d = gap_reload;
            state_d   = StGap;
          end
        end
        default: state_d = StGap;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StGap;
      gap_cnt_q     <= FirstGap;
      level_cnt_q   <= '0;
      lfsr_q        <= LFSR_SEED;
      valid_q       <= 1'b0;
      slot_q        <= 2'd0;
      type_q        <= 2'd0;
      speed_level_q <= 3'd0;
      dx_q          <= BaseDx;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      level_cnt_q   <= level_cnt_d;
      lfsr_q        <= lfsr_d;
      valid_q       <= valid_d;
      slot_q        <= slot_d;
      type_q        <= type_d;
      speed_level_q <= speed_level_d;
      dx_q          <= dx_d;
    end
  end

  assign spawn_valid = valid_q;
  assign spawn_slot  = slot_q;
  assign spawn_type  = type_q;
  assign speed_level = speed_level_q;
  assign dx          = dx_q;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Directed bench for obstacle_spawn_scheduler: table-driven allocation and level vectors plus
// hand-written sequences for handshake hold, stall, freeze and reset during an offer.
module tb_obstacle_spawn_scheduler;

  localparam logic [15:0] Seed = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst, run, tick, spawn_ready;
  logic [2:0] slot_busy;
  logic       spawn_valid;
  logic [1:0] spawn_slot, spawn_type;
  logic [2:0] speed_level;
  logic [4:0] dx;

  always #5 clk = ~clk;

  obstacle_spawn_scheduler #(
    .NUM_SLOTS  (3),
    .LFSR_SEED  (Seed),
    .FIRST_GAP  (4),
    .MIN_GAP    (4),
    .LEVEL_TICKS(8),
    .MAX_LEVEL  (7),
    .BASE_DX    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .tick       (tick),
    .slot_busy  (slot_busy),
    .spawn_ready(spawn_ready),
    .spawn_valid(spawn_valid),
    .spawn_slot (spawn_slot),
    .spawn_type (spawn_type),
    .speed_level(speed_level),
    .dx         (dx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: LFSR, level, type that an allocation this cycle would pick, gap reload.
  logic [15:0] m_lfsr;
  logic [2:0]  m_lcnt;
  logic [2:0]  m_lvl;
  logic [1:0]  m_type;
  logic [7:0]  m_gap;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= Seed;
      m_lcnt <= 3'd0;
      m_lvl  <= 3'd0;
      m_type <= 2'd0;
      m_gap  <= 8'd4;
    end else if (run) begin
      m_lfsr <= lfsr_step(m_lfsr);
      m_type <= (m_lfsr[7:6] == 2'd3 && m_lvl < 3'd2) ? 2'd0 : m_lfsr[7:6];
      if (spawn_ready) m_gap <= 8'd4 + ({2'b00, m_lfsr[5:0]} >> m_lvl[2:1]);
      if (tick) begin
        if (m_lcnt == 3'd7) begin
          m_lcnt <= 3'd0;
          if (m_lvl < 3'd7) m_lvl <= m_lvl + 3'd1;
        end else begin
          m_lcnt <= m_lcnt + 3'd1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse one tick, then allow one idle clk; a spawn must show exactly 2 clks after its tick.
  task automatic count_to_spawn(input int limit, output int n, output bit seen, output bit early);
    n = 0; seen = 1'b0; early = 1'b0;
    while (!seen && n < limit) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      n++;
      if (spawn_valid) begin
        seen  = 1'b1;
        early = 1'b1;
      end else begin
        @(negedge clk);
        if (spawn_valid) seen = 1'b1;
      end
    end
  endtask

  task automatic spawn_and_check(input string nm, input logic [1:0] exp_slot);
    int  n;
    bit  seen, early;
    int  gexp;
    gexp = int'(m_gap);
    count_to_spawn(200, n, seen, early);
    check({nm, " spawn seen"}, 32'(seen), 1);
    check({nm, " tick count"}, n, gexp);
    check({nm, " 2-clk latency"}, 32'(early), 0);
    check({nm, " slot"}, spawn_slot, exp_slot);
    check({nm, " type"}, spawn_type, m_type);
    if (speed_level < 3'd2) check({nm, " no bird below level 2"}, 32'(spawn_type == 2'd3), 0);
  endtask

  task automatic handshake(input string nm);
    spawn_ready = 1'b1;
    @(negedge clk);
    spawn_ready = 1'b0;
    check({nm, " valid drops"}, spawn_valid, 0);
    check({nm, " gap reload"}, dut.gap_cnt_q, m_gap);
  endtask

  typedef struct {
    logic [2:0] busy;
    logic [1:0] slot;
  } alloc_vec_t;

  typedef struct {
    int         ticks;
    logic [2:0] lvl;
    logic [4:0] dx;
  } level_vec_t;

  alloc_vec_t alloc_tab[5];
  level_vec_t level_tab[8];

  initial begin
    int       n, gexp;
    bit       seen, early, got;
    logic [1:0] t0;

    alloc_tab[0] = '{3'b011, 2'd2};
    alloc_tab[1] = '{3'b001, 2'd1};
    alloc_tab[2] = '{3'b110, 2'd0};
    alloc_tab[3] = '{3'b101, 2'd1};
    alloc_tab[4] = '{3'b000, 2'd0};

    // Cumulative ticks: 7, 8, 15, 16, 32, 56, 64, 84.
    level_tab[0] = '{7,  3'd0, 5'd4};
    level_tab[1] = '{1,  3'd1, 5'd5};
    level_tab[2] = '{7,  3'd1, 5'd5};
    level_tab[3] = '{1,  3'd2, 5'd6};
    level_tab[4] = '{16, 3'd4, 5'd8};
    level_tab[5] = '{24, 3'd7, 5'd11};
    level_tab[6] = '{8,  3'd7, 5'd11};
    level_tab[7] = '{20, 3'd7, 5'd11};

    rst = 1'b1; run = 1'b0; tick = 1'b0; spawn_ready = 1'b0; slot_busy = 3'b000;
    repeat (2) @(negedge clk);
    check("reset valid", spawn_valid, 0);
    check("reset level", speed_level, 0);
    check("reset dx", dx, 4);
    check("reset slot", spawn_slot, 0);
    check("reset type", spawn_type, 0);
    rst = 1'b0;
    run = 1'b1;

    // First spawn after FIRST_GAP ticks, then a long hold with ticks and slot churn.
    count_to_spawn(20, n, seen, early);
    check("first spawn seen", 32'(seen), 1);
    check("first spawn ticks", n, 4);
    check("first spawn latency", 32'(early), 0);
    check("first spawn slot", spawn_slot, 0);
    check("first spawn type", spawn_type, m_type);
    t0 = m_type;
    tick = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) slot_busy = 3'b001;
      @(negedge clk);
      check("hold valid", spawn_valid, 1);
      check("hold slot", spawn_slot, 0);
      check("hold type", spawn_type, t0);
    end
    tick = 1'b0;
    slot_busy = 3'b000;
    handshake("first");
    spawn_and_check("second", 2'd0);
    handshake("second");

    for (int i = 0; i < 5; i++) begin
      slot_busy = alloc_tab[i].busy;
      spawn_and_check($sformatf("alloc[%0d]", i), alloc_tab[i].slot);
      handshake($sformatf("alloc[%0d]", i));
    end

    // All slots busy: ALLOC must wait, then take the released slot.
    slot_busy = 3'b111;
    gexp = int'(m_gap);
    count_to_spawn(gexp, n, seen, early);
    check("stall no spawn", 32'(seen), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall valid low", spawn_valid, 0);
    end
    slot_busy = 3'b101;
    got = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (spawn_valid && !got) begin
        got = 1'b1;
        check("release type", spawn_type, m_type);
      end
    end
    check("release valid", spawn_valid, 1);
    check("release slot", spawn_slot, 1);
    handshake("release");

    // Freeze mid-GAP: ticks and ready must be ignored while run is low.
    gexp = int'(m_gap);
    for (int c = 0; c < 2; c++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
    check("pre-freeze gap", dut.gap_cnt_q, gexp - 2);
    run = 1'b0;
    tick = 1'b1;
    spawn_ready = 1'b1;
    repeat (20) @(negedge clk);
    tick = 1'b0;
    spawn_ready = 1'b0;
    check("freeze gap", dut.gap_cnt_q, gexp - 2);
    check("freeze lfsr", dut.lfsr_q, m_lfsr);
    check("freeze level", speed_level, m_lvl);
    check("freeze dx", dx, 5'd4 + {2'b00, m_lvl});
    check("freeze valid", spawn_valid, 0);
    run = 1'b1;
    count_to_spawn(200, n, seen, early);
    check("resume spawn seen", 32'(seen), 1);
    check("resume tick count", n, gexp - 2);
    check("resume slot", spawn_slot, 1);
    check("resume type", spawn_type, m_type);

    // Ready while frozen is not a handshake.
    run = 1'b0;
    spawn_ready = 1'b1;
    repeat (3) @(negedge clk);
    spawn_ready = 1'b0;
    check("frozen ready ignored", spawn_valid, 1);
    run = 1'b1;
    @(negedge clk);
    check("offer kept after freeze", spawn_valid, 1);

    // Reset during OFFER.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst offer valid", spawn_valid, 0);
    check("rst offer level", speed_level, 0);
    check("rst offer dx", dx, 4);
    check("rst offer gap", dut.gap_cnt_q, 4);
    check("rst offer lfsr", dut.lfsr_q, 16'hACE1);

    // Level progression and saturation with back-to-back ticks.
    slot_busy = 3'b000;
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1;
      repeat (level_tab[i].ticks) @(negedge clk);
      tick = 1'b0;
      check($sformatf("level[%0d] speed_level", i), speed_level, level_tab[i].lvl);
      check($sformatf("level[%0d] dx", i), dx, level_tab[i].dx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

endmodule
